// File: rtl/cla_pipe_addsub_if.sv
// Operand/result handshake bundle for the pipelined CLA adder/subtractor.
// The slave side is the adder; the master side is the operand source and result consumer.
interface cla_pipe_addsub_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             co;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, a, b, ci, sub, out_ready,
        input  in_ready, out_valid, s, co, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, ci, sub, out_ready,
        output in_ready, out_valid, s, co, ovf, zero
    );
endinterface

// File: rtl/cla_pipe_addsub.sv
// Pipelined carry-lookahead adder/subtractor: one BLK-bit lookahead block per stage,
// a single registered carry between blocks, valid/ready flow control with global stall.
module cla_pipe_addsub #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned BLK   = 8
) (
    input  logic           clk,
    input  logic           reset_n,
    cla_pipe_addsub_if.slave bus
);
    localparam int unsigned NB       = WIDTH / BLK;
    localparam int unsigned LAST_LSB = (NB - 1) * BLK;

    // Sum-of-products lookahead: every bit carry is formed directly from g/p and the block carry-in.
    function automatic logic [BLK:0] cla_blk(
        input logic [BLK-1:0] x,
        input logic [BLK-1:0] y,
        input logic           cin
    );
        logic [BLK-1:0] g;
        logic [BLK-1:0] p;
        logic [BLK:0]   c;
        logic           acc;
        logic           pp;
        g    = x & y;
        p    = x ^ y;
        c    = '0;
        c[0] = cin;
        for (int k = 0; k < int'(BLK); k++) begin
            acc = 1'b0;
            pp  = 1'b1;
            for (int j = k; j >= 0; j--) begin
                acc = acc | (g[j] & pp);
                pp  = pp & p[j];
            end
            c[k+1] = acc | (pp & cin);
        end
        return {c[BLK], p ^ c[BLK-1:0]};
    endfunction

    logic             stall;
    logic             out_valid_q;
    logic [WIDTH-1:0] s_q;
    logic             co_q;
    logic             ovf_q;
    logic             zero_q;
    logic [WIDTH-1:0] b_op;
    logic             c0;

    // Subtract is a + ~b + 1; ci only matters when adding.
    assign b_op  = bus.sub ? ~bus.b : bus.b;
    assign c0    = bus.sub | bus.ci;
    assign stall = out_valid_q & ~bus.out_ready;

    assign bus.in_ready  = ~stall;
    assign bus.out_valid = out_valid_q;
    assign bus.s         = s_q;
    assign bus.co        = co_q;
    assign bus.ovf       = ovf_q;
    assign bus.zero      = zero_q;

    // State presented to the last block: either the raw inputs or the stage NB-1 register.
    logic             pre_vld;
    logic [WIDTH-1:0] pre_sum;
    logic             pre_cy;
    logic [BLK-1:0]   pre_a;
    logic [BLK-1:0]   pre_b;
    logic             pre_sa;
    logic             pre_sb;

    generate
        if (NB == 1) begin : g_single
            assign pre_vld = bus.in_valid;
            assign pre_sum = '0;
            assign pre_cy  = c0;
            assign pre_a   = bus.a[BLK-1:0];
            assign pre_b   = b_op[BLK-1:0];
            assign pre_sa  = bus.a[WIDTH-1];
            assign pre_sb  = b_op[WIDTH-1];
        end else begin : g_pipe
            localparam int unsigned RW = WIDTH - BLK;

            logic             vld_q   [1:NB-1];
            logic [WIDTH-1:0] sum_q   [1:NB-1];
            logic             cy_q    [1:NB-1];
            logic [RW-1:0]    rem_a_q [1:NB-1];
            logic [RW-1:0]    rem_b_q [1:NB-1];
            logic             sa_q    [1:NB-1];
            logic             sb_q    [1:NB-1];
            logic [WIDTH-1:0] nxt_sum [1:NB-1];
            logic             nxt_cy  [1:NB-1];

            // Block k-1 feeds stage k; block 0 works straight off the inputs.
            always_comb begin : nxt_calc
                logic [BLK:0] r;
                for (int k = 1; k < int'(NB); k++) begin
                    nxt_sum[k] = '0;
                    nxt_cy[k]  = 1'b0;
                end
                r          = cla_blk(bus.a[BLK-1:0], b_op[BLK-1:0], c0);
                nxt_sum[1] = WIDTH'(r[BLK-1:0]);
                nxt_cy[1]  = r[BLK];
                for (int k = 2; k < int'(NB); k++) begin
                    r          = cla_blk(rem_a_q[k-1][BLK-1:0], rem_b_q[k-1][BLK-1:0], cy_q[k-1]);
                    nxt_sum[k] = sum_q[k-1] | (WIDTH'(r[BLK-1:0]) << ((k - 1) * int'(BLK)));
                    nxt_cy[k]  = r[BLK];
                end
            end

            // Unprocessed operand slices are kept right-aligned so the next block is always [BLK-1:0].
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    for (int k = 1; k < int'(NB); k++) begin
                        vld_q[k]   <= 1'b0;
                        sum_q[k]   <= '0;
                        cy_q[k]    <= 1'b0;
                        rem_a_q[k] <= '0;
                        rem_b_q[k] <= '0;
                        sa_q[k]    <= 1'b0;
                        sb_q[k]    <= 1'b0;
                    end
                end else if (!stall) begin
                    vld_q[1]   <= bus.in_valid;
                    sum_q[1]   <= nxt_sum[1];
                    cy_q[1]    <= nxt_cy[1];
                    rem_a_q[1] <= bus.a[WIDTH-1:BLK];
                    rem_b_q[1] <= b_op[WIDTH-1:BLK];
                    sa_q[1]    <= bus.a[WIDTH-1];
                    sb_q[1]    <= b_op[WIDTH-1];
                    for (int k = 2; k < int'(NB); k++) begin
                        vld_q[k]   <= vld_q[k-1];
                        sum_q[k]   <= nxt_sum[k];
                        cy_q[k]    <= nxt_cy[k];
                        rem_a_q[k] <= rem_a_q[k-1] >> BLK;
                        rem_b_q[k] <= rem_b_q[k-1] >> BLK;
                        sa_q[k]    <= sa_q[k-1];
                        sb_q[k]    <= sb_q[k-1];
                    end
                end
            end

            assign pre_vld = vld_q[NB-1];
            assign pre_sum = sum_q[NB-1];
            assign pre_cy  = cy_q[NB-1];
            assign pre_a   = rem_a_q[NB-1][BLK-1:0];
            assign pre_b   = rem_b_q[NB-1][BLK-1:0];
            assign pre_sa  = sa_q[NB-1];
            assign pre_sb  = sb_q[NB-1];
        end
    endgenerate

    logic [BLK:0]     fin_r;
    logic [WIDTH-1:0] fin_sum;

    always_comb begin
        fin_r   = cla_blk(pre_a, pre_b, pre_cy);
        fin_sum = pre_sum | (WIDTH'(fin_r[BLK-1:0]) << LAST_LSB);
    end

    // Output stage: result fields only update on a valid word, so they hold across bubbles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            s_q         <= '0;
            co_q        <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
        end else if (!stall) begin
            out_valid_q <= pre_vld;
            if (pre_vld) begin
                s_q    <= fin_sum;
                co_q   <= fin_r[BLK];
                ovf_q  <= (pre_sa == pre_sb) & (fin_sum[WIDTH-1] != pre_sa);
                zero_q <= (fin_sum == '0);
            end
        end
    end
endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Scoreboard bench for cla_pipe_addsub in three shapes (32/8, 16/4, 32/32) driven in lockstep.
module tb_cla_pipe_addsub;
    localparam int ND = 3;

    typedef struct {
        logic [31:0] s;
        logic        co;
        logic        ovf;
        logic        zero;
        logic        lat;
        int          acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        ci;
    logic        sub;
    logic        out_ready;
    logic [31:0] a;
    logic [31:0] b;

    always #5 clk = ~clk;

    cla_pipe_addsub_if #(.WIDTH(32)) m0 ();
    cla_pipe_addsub_if #(.WIDTH(16)) m1 ();
    cla_pipe_addsub_if #(.WIDTH(32)) m2 ();

    assign m0.in_valid = in_valid;  assign m0.a = a;        assign m0.b = b;
    assign m0.ci = ci;              assign m0.sub = sub;    assign m0.out_ready = out_ready;
    assign m1.in_valid = in_valid;  assign m1.a = a[15:0];  assign m1.b = b[15:0];
    assign m1.ci = ci;              assign m1.sub = sub;    assign m1.out_ready = out_ready;
    assign m2.in_valid = in_valid;  assign m2.a = a;        assign m2.b = b;
    assign m2.ci = ci;              assign m2.sub = sub;    assign m2.out_ready = out_ready;

    cla_pipe_addsub #(.WIDTH(32), .BLK(8))  dut0 (.clk(clk), .reset_n(reset_n), .bus(m0.slave));
    cla_pipe_addsub #(.WIDTH(16), .BLK(4))  dut1 (.clk(clk), .reset_n(reset_n), .bus(m1.slave));
    cla_pipe_addsub #(.WIDTH(32), .BLK(32)) dut2 (.clk(clk), .reset_n(reset_n), .bus(m2.slave));

    logic [ND-1:0] ov, rdy, cov, ovfv, zv;
    logic [31:0]   sv [ND];

    assign ov[0] = m0.out_valid; assign rdy[0] = m0.in_ready; assign sv[0] = m0.s;
    assign cov[0] = m0.co;       assign ovfv[0] = m0.ovf;     assign zv[0] = m0.zero;
    assign ov[1] = m1.out_valid; assign rdy[1] = m1.in_ready; assign sv[1] = {16'h0, m1.s};
    assign cov[1] = m1.co;       assign ovfv[1] = m1.ovf;     assign zv[1] = m1.zero;
    assign ov[2] = m2.out_valid; assign rdy[2] = m2.in_ready; assign sv[2] = m2.s;
    assign cov[2] = m2.co;       assign ovfv[2] = m2.ovf;     assign zv[2] = m2.zero;

    exp_t expq [ND][$];
    exp_t mon_e;
    exp_t hexp;
    logic hv;
    logic lat_tag;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int unsigned wd(input int d);
        return (d == 1) ? 32'd16 : 32'd32;
    endfunction

    function automatic int nb(input int d);
        return (d == 2) ? 1 : 4;
    endfunction

    // Behavioural reference: plain wide addition, no lookahead structure.
    function automatic exp_t model(input int unsigned w, input logic [31:0] x, input logic [31:0] y,
                                   input logic c, input logic sb);
        logic [32:0] mask, xx, yy, full;
        exp_t        e;
        mask   = (33'd1 << w) - 33'd1;
        xx     = {1'b0, x} & mask;
        yy     = (sb ? ~{1'b0, y} : {1'b0, y}) & mask;
        full   = xx + yy + {32'd0, (sb ? 1'b1 : c)};
        e.s    = full[31:0] & mask[31:0];
        e.co   = full[w];
        e.ovf  = (xx[w-1] == yy[w-1]) && (e.s[w-1] != xx[w-1]);
        e.zero = (e.s == 32'd0);
        e.lat  = 1'b0;
        e.acc  = 0;
        return e;
    endfunction

    // Monitor: pops on every output handshake, pushes on every input handshake.
    always @(negedge clk) begin
        for (int d = 0; d < ND; d++) begin
            if (!reset_n) begin
                expq[d].delete();
            end else begin
                if (ov[d] && out_ready) begin
                    checks++;
                    if (expq[d].size() == 0) begin
                        errors++;
                        $display("FAIL dut%0d unexpected_output: got s=%h, want no output", d, sv[d]);
                    end else begin
                        mon_e = expq[d].pop_front();
                        if (sv[d] !== mon_e.s || cov[d] !== mon_e.co || ovfv[d] !== mon_e.ovf || zv[d] !== mon_e.zero) begin
                            errors++;
                            $display("FAIL dut%0d result: got s=%h co=%b ovf=%b zero=%b, want s=%h co=%b ovf=%b zero=%b",
                                     d, sv[d], cov[d], ovfv[d], zv[d], mon_e.s, mon_e.co, mon_e.ovf, mon_e.zero);
                        end
                        if (mon_e.lat) begin
                            checks++;
                            if (cyc - mon_e.acc != nb(d)) begin
                                errors++;
                                $display("FAIL dut%0d latency: got %0d, want %0d", d, cyc - mon_e.acc, nb(d));
                            end
                        end
                    end
                end
                if (in_valid && rdy[d]) begin
                    mon_e     = (d == 0 && hv) ? hexp : model(wd(d), a, b, ci, sub);
                    mon_e.lat = lat_tag;
                    mon_e.acc = cyc;
                    expq[d].push_back(mon_e);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, want %h", nm, got, want);
        end
    endtask

    task automatic set_op(input logic [31:0] x, input logic [31:0] y, input logic c, input logic sb,
                          input logic [31:0] es, input logic eco, input logic eovf, input logic ez);
        in_valid  = 1'b1;
        a         = x;
        b         = y;
        ci        = c;
        sub       = sb;
        hv        = 1'b1;
        hexp.s    = es;
        hexp.co   = eco;
        hexp.ovf  = eovf;
        hexp.zero = ez;
        hexp.lat  = 1'b0;
        hexp.acc  = 0;
    endtask

    task automatic put(input logic [31:0] x, input logic [31:0] y, input logic c, input logic sb,
                       input logic [31:0] es, input logic eco, input logic eovf, input logic ez);
        set_op(x, y, c, sb, es, eco, eovf, ez);
        step();
        in_valid = 1'b0;
        hv       = 1'b0;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "bench timeout");
    end

    initial begin
        reset_n   = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        ci        = 1'b0;
        sub       = 1'b0;
        out_ready = 1'b1;
        hv        = 1'b0;
        lat_tag   = 1'b0;
        #2 reset_n = 1'b0;
        step();
        step();
        for (int d = 0; d < ND; d++) begin
            check($sformatf("reset_out_valid%0d", d), 32'(ov[d]), 32'd0);
            check($sformatf("reset_s%0d", d), sv[d], 32'd0);
            check($sformatf("reset_flags%0d", d), {29'd0, cov[d], ovfv[d], zv[d]}, 32'd0);
            check($sformatf("reset_in_ready%0d", d), 32'(rdy[d]), 32'd1);
        end
        reset_n = 1'b1;
        step();

        // Directed adds and subtracts, all with out_ready high so latency is exactly NB.
        lat_tag = 1'b1;
        put(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        repeat (5) step();
        put(32'h0000_FFFF, 32'hFFFF_0000, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        put(32'hABAB_BABA, 32'h1234_5678, 1'b1, 1'b0, 32'hBDE0_1133, 1'b0, 1'b0, 1'b0);
        put(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        put(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        put(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
        put(32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        put(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1);
        repeat (6) step();
        lat_tag = 1'b0;

        // Stall with a result waiting: inputs must be refused and the output held.
        out_ready = 1'b0;
        put(32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0, 32'h3333_3333, 1'b0, 1'b0, 1'b0);
        put(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
        put(32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10 && !ov[0]; i++) step();
        check("stall_fill_out_valid", 32'(ov[0]), 32'd1);
        set_op(32'h4000_0000, 32'h4000_0000, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check("stall_in_ready", 32'(rdy[0]), 32'd0);
            check("stall_out_valid", 32'(ov[0]), 32'd1);
            check("stall_s_held", sv[0], 32'h3333_3333);
            step();
        end
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        hv       = 1'b0;
        repeat (8) step();

        // Asynchronous reset mid-cycle with operations in flight.
        put(32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0002, 1'b0, 1'b0, 1'b0);
        put(32'h0000_0002, 32'h0000_0002, 1'b0, 1'b0, 32'h0000_0004, 1'b0, 1'b0, 1'b0);
        put(32'h0000_0003, 32'h0000_0003, 1'b0, 1'b0, 32'h0000_0006, 1'b0, 1'b0, 1'b0);
        #3 reset_n = 1'b0;
        #1;
        for (int d = 0; d < ND; d++) begin
            check($sformatf("midrst_out_valid%0d", d), 32'(ov[d]), 32'd0);
            check($sformatf("midrst_s%0d", d), sv[d], 32'd0);
            check($sformatf("midrst_in_ready%0d", d), 32'(rdy[d]), 32'd1);
        end
        step();
        step();
        reset_n = 1'b1;
        repeat (8) step();

        // Random traffic with random back-pressure against the reference model.
        for (int i = 0; i < 1000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            a         = pick();
            b         = pick();
            ci        = 1'($urandom);
            sub       = 1'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (10) step();
        for (int d = 0; d < ND; d++)
            check($sformatf("drain_pending%0d", d), 32'(expq[d].size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
